fpalu_arbiter: RTL and testbench

FPALU_ARBITER -- requirements
Module: fpalu_arbiter

---
 rtl/fpalu_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_fpalu_arbiter.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fpalu_arbiter.sv
// fpalu_arbiter: round-robin arbiter sharing one FPALU between two requesters.
// Optional build macro FPALU_ARB_TIMEOUT_EN adds a WAIT watchdog that completes
// a hung operation with a qNaN result and sets the sticky oerr flag.
module fpalu_arbiter #(
   parameter int unsigned TIMEOUT = 255
) (
   input  logic        iclock,
   input  logic        ireset_n,
   input  logic        ireq0,
   input  logic        ireq1,
   input  logic [31:0] idataa0,
   input  logic [31:0] idatab0,
   input  logic [31:0] idataa1,
   input  logic [31:0] idatab1,
   input  logic [4:0]  icontrol0,
   input  logic [4:0]  icontrol1,
   output logic        odone0,
   output logic        odone1,
   output logic [31:0] oresult,
   output logic        oowner,
   output logic        obusy,
   output logic [31:0] ofp_dataa,
   output logic [31:0] ofp_datab,
   output logic [4:0]  ofp_control,
   output logic        ofp_start,
   input  logic [31:0] ifp_result,
   input  logic        ifp_ready,
   output logic        oerr
);

   localparam int unsigned DATA_W = 32;
   localparam int unsigned CTRL_W = 5;
   localparam logic [DATA_W-1:0] QNAN = 32'h7FC0_0000;

   // Elaboration-time range check on the watchdog limit
   generate
      if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
         $error("fpalu_arbiter: TIMEOUT must be within 1..65535");
      end
   endgenerate

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISSUE   = 3'd1,
      WAIT    = 3'd2,
      DONE    = 3'd3,
      RELEASE = 3'd4
   } state_t;

   state_t              state_q, state_d;
   logic                last_q, last_d;
   logic                served_q, served_d;
   logic                win;
   logic [DATA_W-1:0]   dataa_d, datab_d, result_d;
   logic [CTRL_W-1:0]   control_d;
   logic                owner_d, start_d, busy_d, done0_d, done1_d, err_d;

`ifdef FPALU_ARB_TIMEOUT_EN
   localparam int unsigned CNT_W = 16;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
   logic [CNT_W-1:0]    cnt_q, cnt_d;
`endif

   // State, pointer and registered outputs
   always_ff @(posedge iclock or negedge ireset_n) begin
      if (!ireset_n) begin
         state_q     <= IDLE;
         last_q      <= 1'b0;
         served_q    <= 1'b0;
         ofp_dataa   <= '0;
         ofp_datab   <= '0;
         ofp_control <= '0;
         ofp_start   <= 1'b0;
         oresult     <= '0;
         oowner      <= 1'b0;
         obusy       <= 1'b0;
         odone0      <= 1'b0;
         odone1      <= 1'b0;
         oerr        <= 1'b0;
`ifdef FPALU_ARB_TIMEOUT_EN
         cnt_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         last_q      <= last_d;
         served_q    <= served_d;
         ofp_dataa   <= dataa_d;
         ofp_datab   <= datab_d;
         ofp_control <= control_d;
         ofp_start   <= start_d;
         oresult     <= result_d;
         oowner      <= owner_d;
         obusy       <= busy_d;
         odone0      <= done0_d;
         odone1      <= done1_d;
         oerr        <= err_d;
`ifdef FPALU_ARB_TIMEOUT_EN
         cnt_q       <= cnt_d;
`endif
      end
   end

   // Next-state, arbitration and next output values
   always_comb begin
      state_d   = state_q;
      last_d    = last_q;
      served_d  = served_q;
      dataa_d   = ofp_dataa;
      datab_d   = ofp_datab;
      control_d = ofp_control;
      result_d  = oresult;
      owner_d   = oowner;
      err_d     = oerr;
`ifdef FPALU_ARB_TIMEOUT_EN
      cnt_d     = cnt_q;
`endif

      // Tie goes to the requester not served last; requester 0 until anyone is served
      win = 1'b0;
      if (ireq0 && ireq1) begin
         win = served_q ? ~last_q : 1'b0;
      end else if (ireq1) begin
         win = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (ireq0 || ireq1) begin
               state_d   = ISSUE;
               owner_d   = win;
               dataa_d   = win ? idataa1 : idataa0;
               datab_d   = win ? idatab1 : idatab0;
               control_d = win ? icontrol1 : icontrol0;
            end
         end
         ISSUE: begin
            state_d = WAIT;
`ifdef FPALU_ARB_TIMEOUT_EN
            cnt_d   = '0;
`endif
         end
         WAIT: begin
            if (ifp_ready) begin
               result_d = ifp_result;
               state_d  = DONE;
            end
`ifdef FPALU_ARB_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               result_d = QNAN;
               err_d    = 1'b1;
               state_d  = DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
`endif
         end
         DONE: begin
            last_d   = oowner;
            served_d = 1'b1;
            state_d  = RELEASE;
         end
         RELEASE: begin
            // Hold until the FPALU drops ready so it cannot complete the next op
            if (!ifp_ready) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

`ifndef FPALU_ARB_TIMEOUT_EN
      err_d = 1'b0;
`endif

      start_d = (state_d == WAIT);
      busy_d  = (state_d != IDLE);
      done0_d = (state_q == DONE) && !oowner;
      done1_d = (state_q == DONE) && oowner;
   end

endmodule

// File: tb/tb_fpalu_arbiter.sv
// Directed self-checking bench for fpalu_arbiter; the FPALU is stubbed by
// driving ifp_ready/ifp_result directly from the stimulus sequence.
`timescale 1ns/1ps
module tb_fpalu_arbiter;

`ifdef FPALU_ARB_TIMEOUT_EN
   localparam int unsigned TB_TIMEOUT = 8;
`else
   localparam int unsigned TB_TIMEOUT = 255;
`endif

   logic        iclock = 1'b0;
   logic        ireset_n;
   logic        ireq0, ireq1;
   logic [31:0] idataa0, idatab0, idataa1, idatab1;
   logic [4:0]  icontrol0, icontrol1;
   logic        odone0, odone1;
   logic [31:0] oresult;
   logic        oowner, obusy;
   logic [31:0] ofp_dataa, ofp_datab;
   logic [4:0]  ofp_control;
   logic        ofp_start;
   logic [31:0] ifp_result;
   logic        ifp_ready;
   logic        oerr;

   int errors = 0;
   int checks = 0;

   fpalu_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
      .iclock(iclock), .ireset_n(ireset_n),
      .ireq0(ireq0), .ireq1(ireq1),
      .idataa0(idataa0), .idatab0(idatab0), .idataa1(idataa1), .idatab1(idatab1),
      .icontrol0(icontrol0), .icontrol1(icontrol1),
      .odone0(odone0), .odone1(odone1), .oresult(oresult), .oowner(oowner),
      .obusy(obusy), .ofp_dataa(ofp_dataa), .ofp_datab(ofp_datab),
      .ofp_control(ofp_control), .ofp_start(ofp_start),
      .ifp_result(ifp_result), .ifp_ready(ifp_ready), .oerr(oerr)
   );

   always #5 iclock = ~iclock;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one rising edge, then settle away from it
   task automatic tick();
      @(posedge iclock);
      #1;
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_start"}, 32'(ofp_start), 32'h0);
      chk({tag, "_done0"}, 32'(odone0), 32'h0);
      chk({tag, "_done1"}, 32'(odone1), 32'h0);
      chk({tag, "_busy"},  32'(obusy), 32'h0);
      chk({tag, "_owner"}, 32'(oowner), 32'h0);
      chk({tag, "_err"},   32'(oerr), 32'h0);
      chk({tag, "_result"}, oresult, 32'h0);
      chk({tag, "_dataa"}, ofp_dataa, 32'h0);
      chk({tag, "_datab"}, ofp_datab, 32'h0);
      chk({tag, "_ctrl"},  32'(ofp_control), 32'h0);
   endtask

   initial begin
      ireset_n = 1'b0;
      ireq0 = 1'b0; ireq1 = 1'b0;
      idataa0 = '0; idatab0 = '0; idataa1 = '0; idatab1 = '0;
      icontrol0 = '0; icontrol1 = '0;
      ifp_result = '0; ifp_ready = 1'b0;

      // Reset state
      tick(); tick();
      chk_all_zero("rst");
      ireset_n = 1'b1;
      tick();
      chk("idle_busy", 32'(obusy), 32'h0);

      // Single op from requester 0, ready after 4 WAIT cycles; stale ready in IDLE ignored
      ifp_ready = 1'b1; ifp_result = 32'hDEAD_BEEF;
      tick();
      chk("idle_ready_ignored_busy", 32'(obusy), 32'h0);
      chk("idle_ready_ignored_res", oresult, 32'h0);
      ifp_ready = 1'b0;
      ireq0 = 1'b1; idataa0 = 32'h3F80_0000; idatab0 = 32'h4000_0000; icontrol0 = 5'd0;
      idataa1 = 32'h1111_1111; idatab1 = 32'h2222_2222; icontrol1 = 5'd7;
      tick();
      chk("a_dataa", ofp_dataa, 32'h3F80_0000);
      chk("a_datab", ofp_datab, 32'h4000_0000);
      chk("a_ctrl", 32'(ofp_control), 32'h0);
      chk("a_owner", 32'(oowner), 32'h0);
      chk("a_busy", 32'(obusy), 32'h1);
      chk("a_start_issue", 32'(ofp_start), 32'h0);
      tick();
      chk("a_start_wait", 32'(ofp_start), 32'h1);
      tick(); tick(); tick();
      chk("a_start_hold", 32'(ofp_start), 32'h1);
      chk("a_no_done_yet", 32'(odone0), 32'h0);
      ifp_ready = 1'b1; ifp_result = 32'h4040_0000;
      tick();
      ifp_ready = 1'b0;
      chk("a_result", oresult, 32'h4040_0000);
      chk("a_start_done", 32'(ofp_start), 32'h0);
      chk("a_done0_lag", 32'(odone0), 32'h0);
      tick();
      chk("a_done0", 32'(odone0), 32'h1);
      chk("a_done1", 32'(odone1), 32'h0);
      ireq0 = 1'b0;
      tick();
      chk("a_done0_one", 32'(odone0), 32'h0);
      chk("a_done1_never", 32'(odone1), 32'h0);
      chk("a_idle_busy", 32'(obusy), 32'h0);
      chk("a_result_hold", oresult, 32'h4040_0000);
      chk("a_owner_hold", 32'(oowner), 32'h0);

      // Simultaneous requests right after reset: 0 first, then 1
      ireset_n = 1'b0;
      #1;
      ireset_n = 1'b1;
      ireq0 = 1'b1; ireq1 = 1'b1;
      idataa0 = 32'hA000_0000; idataa1 = 32'hA111_1111;
      tick();
      chk("b_owner0", 32'(oowner), 32'h0);
      chk("b_dataa0", ofp_dataa, 32'hA000_0000);
      tick();
      ifp_ready = 1'b1; ifp_result = 32'h0000_00B0;
      tick();
      ifp_ready = 1'b0;
      tick();
      chk("b_done0", 32'(odone0), 32'h1);
      chk("b_done1_not_yet", 32'(odone1), 32'h0);
      chk("b_busy_release", 32'(obusy), 32'h1);
      ireq0 = 1'b0;
      tick();
      chk("b_idle_gap", 32'(obusy), 32'h0);
      tick();
      chk("b_owner1", 32'(oowner), 32'h1);
      chk("b_dataa1", ofp_dataa, 32'hA111_1111);
      chk("b_busy_again", 32'(obusy), 32'h1);
      tick();
      // Operand change while in WAIT must not reach the FPALU
      idataa1 = 32'hC000_0000;
      tick();
      chk("f_dataa_stable", ofp_dataa, 32'hA111_1111);
      ifp_ready = 1'b1; ifp_result = 32'h0000_00B1;
      tick();
      ifp_ready = 1'b0;
      chk("b_result1", oresult, 32'h0000_00B1);
      tick();
      chk("b_done1", 32'(odone1), 32'h1);
      chk("b_done0_low", 32'(odone0), 32'h0);
      ireq1 = 1'b0;
      tick();

      // Ready held high after completion; queued requester 1 must wait
      ireq0 = 1'b1; idataa0 = 32'h0C0C_0C0C;
      tick();
      chk("c_owner0", 32'(oowner), 32'h0);
      tick();
      ireq1 = 1'b1; idataa1 = 32'h0D0D_0D0D;
      ifp_ready = 1'b1; ifp_result = 32'h0000_00C2;
      tick();
      tick();
      chk("c_done0", 32'(odone0), 32'h1);
      ireq0 = 1'b0;
      tick();
      chk("c_single_done", 32'(odone0), 32'h0);
      tick(); tick();
      chk("c_hold_busy", 32'(obusy), 32'h1);
      chk("c_hold_owner", 32'(oowner), 32'h0);
      chk("c_hold_start", 32'(ofp_start), 32'h0);
      chk("c_hold_dataa", ofp_dataa, 32'h0C0C_0C0C);
      chk("c_hold_done", 32'(odone0), 32'h0);
      ifp_ready = 1'b0;
      tick();
      chk("c_idle", 32'(obusy), 32'h0);
      tick();
      chk("c_owner1", 32'(oowner), 32'h1);
      chk("c_dataa1", ofp_dataa, 32'h0D0D_0D0D);
      tick();
      ifp_ready = 1'b1; ifp_result = 32'h0000_00C3;
      tick();
      ifp_ready = 1'b0;
      tick();
      chk("c_done1", 32'(odone1), 32'h1);
      ireq1 = 1'b0;
      tick();

      // Asynchronous reset while in WAIT
      ireq0 = 1'b1; idataa0 = 32'h0E0E_0E0E;
      tick(); tick();
      chk("d_in_wait", 32'(ofp_start), 32'h1);
      #2;
      ireset_n = 1'b0;
      #1;
      chk_all_zero("d_async");
      tick();
      chk("d_no_done0", 32'(odone0), 32'h0);
      ireset_n = 1'b1;
      ireq1 = 1'b1;
      tick();
      chk("d_post_owner", 32'(oowner), 32'h0);
      chk("d_post_dataa", ofp_dataa, 32'h0E0E_0E0E);
      tick();
      ifp_ready = 1'b1; ifp_result = 32'h0000_00D4;
      tick();
      ifp_ready = 1'b0;
      tick();
      chk("d_done0", 32'(odone0), 32'h1);
      chk("d_result", oresult, 32'h0000_00D4);
      ireq0 = 1'b0; ireq1 = 1'b0;
      tick();
      chk("d_err", 32'(oerr), 32'h0);

`ifdef FPALU_ARB_TIMEOUT_EN
      // Watchdog: ready never comes
      ireq0 = 1'b1;
      tick(); tick();
      for (int i = 0; i < 7; i++) tick();
      chk("t_still_wait", 32'(ofp_start), 32'h1);
      chk("t_err_clear", 32'(oerr), 32'h0);
      tick();
      chk("t_start_off", 32'(ofp_start), 32'h0);
      chk("t_qnan", oresult, 32'h7FC0_0000);
      chk("t_err_set", 32'(oerr), 32'h1);
      tick();
      chk("t_done0", 32'(odone0), 32'h1);
      ireq0 = 1'b0;
      tick();
      ireq1 = 1'b1;
      tick(); tick();
      ifp_ready = 1'b1; ifp_result = 32'h0000_00E5;
      tick();
      ifp_ready = 1'b0;
      tick();
      chk("t_good_done1", 32'(odone1), 32'h1);
      chk("t_good_result", oresult, 32'h0000_00E5);
      chk("t_err_sticky", 32'(oerr), 32'h1);
      ireq1 = 1'b0;
      tick();
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
